// File: rtl/bit_tx_pkg.sv
// Shared definitions for the NRZ bit-pattern transmitter: mode encoding, FSM states,
// PRBS7 seed/taps and the shortest legal bit period.
package bit_tx_pkg;

  typedef enum logic [1:0] {
    MODE_BYTE  = 2'd0,
    MODE_PRBS7 = 2'd1,
    MODE_ALT   = 2'd2,
    MODE_IDLE  = 2'd3
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [6:0] PRBS7_SEED  = 7'h7F;
  // x^7 + x^6 + 1 in Fibonacci form: feedback from register bits 6 and 5
  localparam logic [2:0] PRBS7_TAP_A = 3'd6;
  localparam logic [2:0] PRBS7_TAP_B = 3'd5;

  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/prbs7_gen.sv
// PRBS7 (x^7+x^6+1) Fibonacci LFSR; reseeded on demand, steps once per advance pulse.
module prbs7_gen
  import bit_tx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic seed_load,
  input  logic advance,
  output logic bit_out
);

  logic [6:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= PRBS7_SEED;
    end else if (seed_load) begin
      lfsr_q <= PRBS7_SEED;
    end else if (advance) begin
      lfsr_q <= {lfsr_q[5:0], lfsr_q[PRBS7_TAP_A] ^ lfsr_q[PRBS7_TAP_B]};
    end
  end

  assign bit_out = lfsr_q[6];

endmodule

// File: rtl/bit_pattern_tx.sv
// Programmable-rate NRZ transmitter (byte stream, PRBS7 or 1010 pattern) with a reference
// bit clock and per-bit strobe, used to exercise the bit-clock-recovery receiver.
module bit_pattern_tx
  import bit_tx_pkg::*;
#(
  parameter int   PERIOD_W       = 32,
  parameter int   DEFAULT_PERIOD = 600,
  parameter logic IDLE_LEVEL     = 1'b0
) (
  input  logic                clk_300M_global,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] bit_period,
  input  logic [7:0]          data_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic                signal_out,
  output logic                bit_clk,
  output logic                bit_strobe,
  output logic                busy,
  output logic                underflow
);

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic                alt_q, alt_d;
  logic                hold_full_q, hold_full_d;
  logic                uf_q, uf_d;
  logic [7:0]          hold_q;
  logic [7:0]          shift_q, shift_d;

  logic accept, boundary, src_avail, seed_load, advance, load_hold, prbs_bit;
  logic signal_p0, bit_clk_p0, strobe_p0, busy_p0;

  function automatic logic [PERIOD_W-1:0] sat_period(input logic [PERIOD_W-1:0] p);
    return (p < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(DEFAULT_PERIOD) : p;
  endfunction

  assign accept   = data_valid && data_ready;
  assign boundary = (cnt_q == period_q - PERIOD_W'(1));

  always_comb begin
    case (mode_t'(mode))
      MODE_BYTE:  src_avail = hold_full_q;
      MODE_PRBS7,
      MODE_ALT:   src_avail = 1'b1;
      default:    src_avail = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    bit_idx_d   = bit_idx_q;
    alt_d       = alt_q;
    shift_d     = shift_q;
    hold_full_d = hold_full_q;
    uf_d        = 1'b0;
    seed_load   = 1'b0;
    advance     = 1'b0;
    load_hold   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable && src_avail) begin
          state_d   = ST_RUN;
          mode_d    = mode_t'(mode);
          period_d  = sat_period(bit_period);
          bit_idx_d = '0;
          alt_d     = 1'b1;
          seed_load = 1'b1;
          if (mode_t'(mode) == MODE_BYTE) begin
            shift_d   = hold_q;
            load_hold = 1'b1;
          end
        end
      end
      default: begin
        if (boundary) begin
          cnt_d    = '0;
          period_d = sat_period(bit_period);
          alt_d    = ~alt_q;
          advance  = (mode_q == MODE_PRBS7);
          if (mode_q == MODE_BYTE) begin
            // Byte mode only honours enable at byte ends; a late handshake cannot save it
            if (bit_idx_q == 3'd7) begin
              if (!enable) begin
                state_d = ST_IDLE;
              end else if (hold_full_q) begin
                shift_d   = hold_q;
                load_hold = 1'b1;
                bit_idx_d = '0;
              end else begin
                state_d = ST_IDLE;
                uf_d    = 1'b1;
              end
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else if (!enable) begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
    endcase

    if (load_hold) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
    end
  end

  prbs7_gen u_prbs7 (
    .clk       (clk_300M_global),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .advance   (advance),
    .bit_out   (prbs_bit)
  );

  // Output register stage: line, reference clock and strobe lag the bit counter by one cycle
  always_comb begin
    signal_p0  = IDLE_LEVEL;
    bit_clk_p0 = 1'b0;
    strobe_p0  = 1'b0;
    busy_p0    = 1'b0;
    if (state_q == ST_RUN) begin
      busy_p0    = 1'b1;
      strobe_p0  = (cnt_q == '0);
      bit_clk_p0 = (cnt_q < (period_q >> 1));
      case (mode_q)
        MODE_BYTE:  signal_p0 = shift_q[7];
        MODE_PRBS7: signal_p0 = prbs_bit;
        MODE_ALT:   signal_p0 = alt_q;
        default:    signal_p0 = IDLE_LEVEL;
      endcase
    end
  end

  always_ff @(posedge clk_300M_global) begin
    shift_q <= shift_d;
    if (accept) begin
      hold_q <= data_in;
    end
  end

  always_ff @(posedge clk_300M_global or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_BYTE;
      cnt_q       <= '0;
      period_q    <= PERIOD_W'(DEFAULT_PERIOD);
      bit_idx_q   <= '0;
      alt_q       <= 1'b1;
      hold_full_q <= 1'b0;
      uf_q        <= 1'b0;
      data_ready  <= 1'b1;
      signal_out  <= IDLE_LEVEL;
      bit_clk     <= 1'b0;
      bit_strobe  <= 1'b0;
      busy        <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      bit_idx_q   <= bit_idx_d;
      alt_q       <= alt_d;
      hold_full_q <= hold_full_d;
      uf_q        <= uf_d;
      data_ready  <= !hold_full_d;
      signal_out  <= signal_p0;
      bit_clk     <= bit_clk_p0;
      bit_strobe  <= strobe_p0;
      busy        <= busy_p0;
      underflow   <= uf_q;
    end
  end

endmodule

// File: tb/tb_bit_pattern_tx.sv
// Scoreboard bench for bit_pattern_tx: expected line bits are queued when a stream is started
// and popped on every bit_strobe.
`timescale 1ns/1ps
module tb_bit_pattern_tx;
  import bit_tx_pkg::*;

  logic        clk_300M_global = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic [31:0] bit_period;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready, signal_out, bit_clk, bit_strobe, busy, underflow;

  int errors = 0;
  int checks = 0;
  logic exp_q[$];

  always #5 clk_300M_global = ~clk_300M_global;

  bit_pattern_tx dut (
    .clk_300M_global (clk_300M_global),
    .rst_n           (rst_n),
    .enable          (enable),
    .mode            (mode),
    .bit_period      (bit_period),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .data_ready      (data_ready),
    .signal_out      (signal_out),
    .bit_clk         (bit_clk),
    .bit_strobe      (bit_strobe),
    .busy            (busy),
    .underflow       (underflow)
  );

  task automatic send_byte(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_300M_global);
      if (data_ready) break;
    end
    @(posedge clk_300M_global);
    #1 data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; data_valid = 1'b0; mode = MODE_BYTE;
    bit_period = 32'd10; data_in = 8'h00;
    exp_q.delete();
    repeat (3) @(posedge clk_300M_global);
    @(negedge clk_300M_global);
    checks++; if (signal_out !== 1'b0) begin errors++; $display("FAIL reset_signal got=%b exp=0", signal_out); end
    checks++; if (bit_clk !== 1'b0) begin errors++; $display("FAIL reset_bit_clk got=%b exp=0", bit_clk); end
    checks++; if (bit_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%b exp=0", bit_strobe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL reset_data_ready got=%b exp=1", data_ready); end
    @(posedge clk_300M_global);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk_300M_global);
    #1;
  endtask

  task automatic test_byte_b2b();
    int nstrobe = 0, last = -1, uf_cnt = 0, end_cyc = -1;
    logic [15:0] pattern = 16'hA53C;
    logic e;
    exp_q.delete();
    for (int i = 15; i >= 0; i--) exp_q.push_back(pattern[i]);
    mode = MODE_BYTE; bit_period = 32'd10; enable = 1'b1;
    fork
      begin
        send_byte(8'hA5);
        send_byte(8'h3C);
      end
      begin
        for (int cyc = 0; cyc < 300; cyc++) begin
          @(negedge clk_300M_global);
          if (underflow) uf_cnt++;
          if (bit_strobe) begin
            nstrobe++;
            if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 1'bx;
            checks++;
            if (signal_out !== e) begin errors++; $display("FAIL b2b_bit%0d got=%b exp=%b", nstrobe, signal_out, e); end
            if (last >= 0) begin
              checks++;
              if (cyc - last != 10) begin errors++; $display("FAIL b2b_len%0d got=%0d exp=10", nstrobe - 1, cyc - last); end
            end
            last = cyc;
          end
          if (nstrobe == 16 && !busy && end_cyc < 0) begin
            end_cyc = cyc;
            checks++; if (cyc - last != 10) begin errors++; $display("FAIL b2b_last_len got=%0d exp=10", cyc - last); end
            checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL b2b_uf_at_end got=%b exp=1", underflow); end
            checks++; if (signal_out !== 1'b0) begin errors++; $display("FAIL b2b_idle_line got=%b exp=0", signal_out); end
          end
        end
      end
    join
    checks++; if (nstrobe != 16) begin errors++; $display("FAIL b2b_strobes got=%0d exp=16", nstrobe); end
    checks++; if (uf_cnt != 1) begin errors++; $display("FAIL b2b_uf_count got=%0d exp=1", uf_cnt); end
    checks++; if (end_cyc < 0) begin errors++; $display("FAIL b2b_end_timeout got=%0d exp=>=0", end_cyc); end
    enable = 1'b0;
  endtask

  task automatic test_prbs7();
    logic b[140];
    logic [13:0] ref14 = 14'b11111110000001;
    int nstrobe = 0, last = -1, hi = 0;
    logic e;
    for (int i = 0; i < 7; i++) b[i] = 1'b1;
    for (int i = 7; i < 140; i++) b[i] = b[i-7] ^ b[i-6];
    exp_q.delete();
    for (int i = 0; i < 140; i++) exp_q.push_back(b[i]);
    mode = MODE_PRBS7; bit_period = 32'd4; enable = 1'b1;
    for (int cyc = 0; cyc < 700 && nstrobe < 140; cyc++) begin
      @(negedge clk_300M_global);
      if (bit_strobe) begin
        nstrobe++;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 1'bx;
        checks++;
        if (signal_out !== e) begin errors++; $display("FAIL prbs_bit%0d got=%b exp=%b", nstrobe, signal_out, e); end
        if (nstrobe <= 14) begin
          checks++;
          if (signal_out !== ref14[14-nstrobe]) begin errors++; $display("FAIL prbs_head%0d got=%b exp=%b", nstrobe, signal_out, ref14[14-nstrobe]); end
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 4 || hi != 2) begin errors++; $display("FAIL prbs_clk%0d len=%0d hi=%0d exp len=4 hi=2", nstrobe - 1, cyc - last, hi); end
        end
        last = cyc;
        hi = 0;
      end
      if (bit_clk) hi++;
    end
    checks++; if (nstrobe != 140) begin errors++; $display("FAIL prbs_count got=%0d exp=140", nstrobe); end
    enable = 1'b0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk_300M_global);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prbs_stop got busy=%b exp=0", busy); end
  endtask

  task automatic test_alt_period();
    int exp_len[3] = '{6, 9, 600};
    int nstrobe = 0, last = -1, end_cyc = -1;
    logic e;
    exp_q.delete();
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    mode = MODE_ALT; bit_period = 32'd6; enable = 1'b1;
    for (int cyc = 0; cyc < 1500 && end_cyc < 0; cyc++) begin
      @(negedge clk_300M_global);
      if (bit_strobe) begin
        nstrobe++;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 1'bx;
        checks++;
        if (signal_out !== e) begin errors++; $display("FAIL alt_bit%0d got=%b exp=%b", nstrobe, signal_out, e); end
        if (nstrobe >= 2 && nstrobe <= 4) begin
          checks++;
          if (cyc - last != exp_len[nstrobe-2]) begin errors++; $display("FAIL alt_len%0d got=%0d exp=%0d", nstrobe - 1, cyc - last, exp_len[nstrobe-2]); end
        end
        last = cyc;
        @(posedge clk_300M_global);
        #1;
        if (nstrobe == 1) bit_period = 32'd9;
        if (nstrobe == 2) bit_period = 32'd1;
        if (nstrobe == 4) enable = 1'b0;
      end else if (nstrobe == 4 && !busy) begin
        end_cyc = cyc;
        checks++; if (cyc - last != 600) begin errors++; $display("FAIL alt_len4 got=%0d exp=600", cyc - last); end
      end
    end
    checks++; if (end_cyc < 0 || nstrobe != 4) begin errors++; $display("FAIL alt_end strobes=%0d end=%0d exp strobes=4", nstrobe, end_cyc); end
    enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    int nstrobe = 0, uf_cnt = 0, done = 0;
    logic e;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
    mode = MODE_BYTE; bit_period = 32'd5; enable = 1'b1;
    send_byte(8'hFF);
    for (int cyc = 0; cyc < 200 && done == 0; cyc++) begin
      @(negedge clk_300M_global);
      if (underflow) uf_cnt++;
      if (bit_strobe) begin
        nstrobe++;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 1'bx;
        checks++;
        if (signal_out !== e) begin errors++; $display("FAIL drop_bit%0d got=%b exp=%b", nstrobe, signal_out, e); end
        if (nstrobe == 3) begin
          @(posedge clk_300M_global);
          #1 enable = 1'b0;
        end
      end else if (nstrobe > 0 && !busy) begin
        done = 1;
      end
    end
    repeat (3) begin
      @(negedge clk_300M_global);
      if (underflow) uf_cnt++;
    end
    checks++; if (nstrobe != 8) begin errors++; $display("FAIL drop_strobes got=%0d exp=8", nstrobe); end
    checks++; if (uf_cnt != 0) begin errors++; $display("FAIL drop_underflow got=%0d exp=0", uf_cnt); end
    checks++; if (signal_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drop_idle got line=%b busy=%b exp 0 0", signal_out, busy); end
  endtask

  task automatic test_odd_period();
    int nstrobe = 0, hi = 0, lo = 0, last = -1;
    mode = MODE_ALT; bit_period = 32'd7; enable = 1'b1;
    for (int cyc = 0; cyc < 100 && nstrobe < 5; cyc++) begin
      @(negedge clk_300M_global);
      if (bit_strobe) begin
        nstrobe++;
        if (last >= 0) begin
          checks++;
          if (hi != 3 || lo != 4) begin errors++; $display("FAIL odd_clk%0d hi=%0d lo=%0d exp hi=3 lo=4", nstrobe - 1, hi, lo); end
        end
        last = cyc; hi = 0; lo = 0;
      end
      if (bit_clk) hi++; else lo++;
    end
    checks++; if (nstrobe != 5) begin errors++; $display("FAIL odd_count got=%0d exp=5", nstrobe); end
    enable = 1'b0;
    for (int i = 0; i < 30 && busy; i++) @(negedge clk_300M_global);
    checks++; if (busy !== 1'b0 || bit_clk !== 1'b0) begin errors++; $display("FAIL odd_stop busy=%b bit_clk=%b exp 0 0", busy, bit_clk); end
  endtask

  task automatic test_reset_midbyte();
    exp_q.delete();
    mode = MODE_BYTE; bit_period = 32'd10; enable = 1'b1;
    send_byte(8'hFF);
    send_byte(8'h00);
    repeat (25) @(negedge clk_300M_global);
    checks++; if (busy !== 1'b1 || data_ready !== 1'b0 || signal_out !== 1'b1) begin
      errors++; $display("FAIL mid_pre busy=%b ready=%b line=%b exp 1 0 1", busy, data_ready, signal_out);
    end
    @(posedge clk_300M_global);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (signal_out !== 1'b0 || busy !== 1'b0 || bit_clk !== 1'b0 || bit_strobe !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL mid_async line=%b busy=%b clk=%b strobe=%b uf=%b exp all 0", signal_out, busy, bit_clk, bit_strobe, underflow);
    end
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL mid_async_ready got=%b exp=1", data_ready); end
    @(posedge clk_300M_global);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk_300M_global);
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL mid_after_ready got=%b exp=1", data_ready); end
    checks++; if (busy !== 1'b0 || signal_out !== 1'b0) begin errors++; $display("FAIL mid_after_idle busy=%b line=%b exp 0 0", busy, signal_out); end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_byte_b2b();
    test_prbs7();
    test_alt_period();
    test_enable_drop();
    test_odd_period();
    test_reset_midbyte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bit_pattern_tx.md
# bit_pattern_tx

Programmable-rate NRZ bit-stream transmitter, clocked from the 300 MHz global base clock. It produces the serial `signal` that the bit-clock-recovery receiver consumes, so the receiver can be exercised on the board with known rates and patterns. Alongside the data it drives a reference bit clock and a per-bit strobe, which let a scope or checker compare the transmitted clock against `clk_rec`.

## Interface
Parameters:
- `PERIOD_W`, default 32: width of the bit-period value, in base-clock cycles.
- `DEFAULT_PERIOD`, default 600: bit period used when `bit_period` is below the minimum. 600 cycles gives 500 kbit/s at 300 MHz.
- `IDLE_LEVEL`, default 1'b0: line level driven while idle.

Ports:
- `clk_300M_global`, in, 1: single clock. Every register uses its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: request transmission.
- `mode`, in, 2: 0 = BYTE stream, 1 = PRBS7, 2 = ALT (1010…), 3 = IDLE_ONLY.
- `bit_period`, in, `PERIOD_W`: cycles per bit.
- `data_in`, in, 8: byte to send in BYTE mode, MSB first.
- `data_valid`, in, 1: `data_in` is valid.
- `data_ready`, out, 1: holding register is empty.
- `signal_out`, out, 1: serial NRZ line.
- `bit_clk`, out, 1: reference clock, high for the first half of each bit.
- `bit_strobe`, out, 1: one-cycle pulse in the first cycle of each bit.
- `busy`, out, 1: FSM is in RUN.
- `underflow`, out, 1: one-cycle pulse when a byte stream starves.

## Operation
- Byte handshake: a byte transfers into the 8-bit holding register when `data_valid && data_ready`.
  - `data_ready` is registered and equals the inverse of the holding register's full flag.
  - There is no same-cycle bypass.
- FSM states are IDLE and RUN.
  - IDLE → RUN when `enable` is high and a source is available.
  - In BYTE mode a source is available when the holding register is full.
  - In PRBS7 and ALT modes a source is always available.
  - IDLE_ONLY never leaves IDLE.
- Mode latch: `mode` is latched on the IDLE→RUN transition. Changing `mode` during RUN has no effect until the next IDLE.
- Bit counter `cnt` runs 0 … `period_q`−1. The bit boundary is the cycle where `cnt == period_q−1`.
- Period latch: `period_q` is loaded from `bit_period` at the start of every bit.
  - Any value below 2 is replaced by `DEFAULT_PERIOD`.
  - A change therefore takes effect on the next bit and never truncates the current bit.
- BYTE mode:
  - The shift register loads from the holding register at the RUN entry.
  - It also loads at the boundary of bit 7, provided the holding register is full. That load frees the holding register.
  - If the holding register is empty at the bit-7 boundary, the FSM goes to IDLE and `underflow` pulses for one cycle.
- PRBS7 mode:
  - Polynomial x⁷+x⁶+1, Fibonacci form; the output is bit 6.
  - Reseeded to 7'h7F on each RUN entry, and advances once per bit boundary.
  - The first 7 bits are 1111111, followed by 0000001.
- ALT mode: the first bit is 1, and the level toggles at every boundary.
- Dropping `enable` in RUN: the current bit completes.
  - In BYTE mode the current byte also completes.
  - The FSM then goes to IDLE. No underflow is flagged.
- While idle, `signal_out = IDLE_LEVEL` and `bit_clk = 0`.

## Timing
- Reset values: `signal_out = IDLE_LEVEL`, `bit_clk = 0`, `bit_strobe = 0`, `busy = 0`, `underflow = 0`, `data_ready = 1`. State = IDLE, `cnt = 0`, holding register empty.
- All outputs are registered.
- Startup latency: `signal_out` shows the first bit 1 cycle after the IDLE→RUN decision.
  - In BYTE mode this is 2 cycles after the accepting `data_valid` edge.
  - `bit_strobe` and `busy` assert in the same cycle as the first bit.
- Bit length: each bit lasts exactly `period_q` cycles, and `bit_strobe` is asserted in that bit's first cycle.
- Reference clock: `bit_clk` is 1 while `cnt < (period_q >> 1)`.
  - For an odd period, the high half is one cycle shorter.
- `data_ready` rises 1 cycle after the holding→shift load.
  - Back-to-back bytes produce no gap, provided the next byte is accepted before the bit-7 boundary.
- Simultaneous events at a boundary:
  - A `data_valid` handshake in the same cycle as the bit-7 boundary with an empty holding register is too late: underflow still occurs. The byte stays held and restarts RUN from IDLE.
  - `enable` deasserting in a boundary cycle ends transmission at that boundary.
- Asynchronous reset mid-bit: all outputs return to their reset values immediately and the holding register empties. There is no partial bit afterward.

## Structure
- Package `bit_tx_pkg`:
  - mode encoding (`MODE_BYTE`, `MODE_PRBS7`, `MODE_ALT`, `MODE_IDLE`)
  - FSM state type
  - `PRBS7_SEED = 7'h7F`
  - PRBS7 tap positions
  - `MIN_PERIOD = 2`
- Sub-module `prbs7_gen`, interface: `clk`, `rst_n`, `seed_load`, `advance`, `bit_out`.
- All other logic stays in `bit_pattern_tx`: counter, period latch, holding and shift registers, FSM.

## Test plan
- BYTE, period 10, bytes 8'hA5 then 8'h3C sent back-to-back → line shows 1010010100111100 with no gap. Each bit lasts 10 cycles, with 16 strobes. `underflow` pulses once after the last bit, then the line returns to 0.
- PRBS7, period 4 → the first 14 bits are 11111110000001 and the sequence repeats every 127 bits. `bit_clk` is high 2 cycles / low 2 cycles per bit.
- ALT, `bit_period` changed from 6 to 9 mid-bit → the current bit stays 6 cycles and the next bit is 9 cycles. `bit_period` = 1 → bits last 600 cycles.
- BYTE, `enable` dropped after bit 2 of 8'hFF → all 8 bits are sent, then IDLE, with no `underflow`.
- Period 7 → `bit_clk` is high 3 cycles / low 4 cycles per bit.
- `rst_n` asserted mid-byte → outputs return to their reset values in the same cycle, and `data_ready` = 1 after release.
